shift_arbiter_2to1: RTL

SHIFT_ARBITER_2TO1 -- requirements
Module: shift_arbiter_2to1

---
 rtl/shift_arbiter_2to1_pkg.sv | 10 +
 rtl/rr_arbiter_2.sv | 41 ++++
 rtl/shift_arbiter_2to1.sv | 87 ++++++++
 3 files changed

// File: rtl/shift_arbiter_2to1_pkg.sv
// Shared constants and types for the 2:1 shift arbiter: default widths and
// the requester-index type used by the arbiter and the datapath.
package shift_arbiter_2to1_pkg;

  localparam int N_DEFAULT = 16;
  localparam int S_DEFAULT = 4;

  typedef logic req_idx_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin arbiter: owns the priority pointer, produces a
// one-hot grant and its index, and advances priority only on an accepted grant.
module rr_arbiter_2
  import shift_arbiter_2to1_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       load_i,
  output logic [1:0] gnt_o,
  output req_idx_t   gnt_idx_o
);

  logic prio_q, prio_d;

  always_comb begin
    gnt_o     = 2'b00;
    gnt_idx_o = 1'b0;
    case (req_i)
      2'b01: begin gnt_o = 2'b01; gnt_idx_o = 1'b0; end
      2'b10: begin gnt_o = 2'b10; gnt_idx_o = 1'b1; end
      2'b11: begin
        gnt_o     = prio_q ? 2'b10 : 2'b01;
        gnt_idx_o = prio_q;
      end
      default: begin gnt_o = 2'b00; gnt_idx_o = 1'b0; end
    endcase
  end

  // The winner yields priority to the other requester.
  always_comb begin
    prio_d = prio_q;
    if (load_i && (req_i != 2'b00)) prio_d = ~gnt_idx_o;
  end

  always_ff @(posedge clk) begin
    if (rst) prio_q <= 1'b0;
    else     prio_q <= prio_d;
  end

endmodule

// File: rtl/shift_arbiter_2to1.sv
// Two requesters share one left-shifter through a 2:1 operand mux; the
// result sits in a single output register with valid/ready flow control.
module shift_arbiter_2to1
  import shift_arbiter_2to1_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int S = S_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in0_valid,
  output logic         in0_ready,
  input  logic [N-1:0] in0_a,
  input  logic [S-1:0] in0_b,
  input  logic         in1_valid,
  output logic         in1_ready,
  input  logic [N-1:0] in1_a,
  input  logic [S-1:0] in1_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_c,
  output logic         out_src
);

  // Zero-filled left shift; shifts of N or more leave nothing behind.
  function automatic logic [N-1:0] shl_fill(input logic [N-1:0] a,
                                            input logic [S-1:0] b);
    return a << b;
  endfunction

  logic         out_valid_q, out_valid_d;
  logic [N-1:0] out_c_q, out_c_d;
  logic         out_src_q, out_src_d;
  logic         load;
  logic [1:0]   gnt;
  req_idx_t     gnt_idx;
  logic [N-1:0] a_mux;
  logic [S-1:0] b_mux;

  assign load = !out_valid_q || out_ready;

  rr_arbiter_2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     ({in1_valid, in0_valid}),
    .load_i    (load),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign in0_ready = !rst && load && gnt[0];
  assign in1_ready = !rst && load && gnt[1];

  assign a_mux = gnt_idx ? in1_a : in0_a;
  assign b_mux = gnt_idx ? in1_b : in0_b;

  always_comb begin
    out_valid_d = out_valid_q;
    out_c_d     = out_c_q;
    out_src_d   = out_src_q;
    if (load) begin
      out_valid_d = (gnt != 2'b00);
      if (gnt != 2'b00) begin
        out_c_d   = shl_fill(a_mux, b_mux);
        out_src_d = gnt_idx;
      end
    end
  end

  // Output register stage: reset clears data as well so a dropped result can never reappear.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_c_q     <= '0;
      out_src_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_c_q     <= out_c_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_c     = out_c_q;
  assign out_src   = out_src_q;

endmodule
